// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared edge/center-aligned period counter and a duty
// comparator per channel. Period and duty are double-buffered and reload only at the period boundary.
module pwm_multi_gen #(
  parameter int CH             = 4,
  parameter int CNT_W          = 12,
  parameter int DEFAULT_PERIOD = 3999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             center,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic [CH-1:0]    pwm_out,
  output logic             period_tick
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [CNT_W-1:0] per_sh;
  logic [CNT_W-1:0] per_act;
  logic [CNT_W-1:0] duty_sh  [CH];
  logic [CNT_W-1:0] duty_act [CH];
  logic             mode_act;

  logic [CNT_W-1:0] cnt, cnt_next;
  dir_t             dir, dir_next;
  logic             center_eff;
  logic             period_end;
  logic             reload;
  logic [CH-1:0]    pwm_next;
  logic             tick_next;

  // NOTE: the shadow/active duty banks are a handful of flops with architectural reset
  // values, so they are reset like any other register rather than treated as RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_sh <= RESET_PERIOD;
      for (int i = 0; i < CH; i++) duty_sh[i] <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == 3'd0) per_sh <= cfg_wdata;
      for (int i = 0; i < CH; i++) begin
        if (cfg_addr == 3'(i + 1)) duty_sh[i] <= cfg_wdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so a write landing on a reload
  // edge is seen by the reload as the pre-edge shadow value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_act  <= RESET_PERIOD;
      mode_act <= 1'b0;
      for (int i = 0; i < CH; i++) duty_act[i] <= '0;
    end else if (reload) begin
      per_act  <= per_sh;
      mode_act <= center;
      for (int i = 0; i < CH; i++) duty_act[i] <= duty_sh[i];
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cnt_next;
      dir <= dir_next;
    end
  end

  // Next-state logic. A zero period in center mode degenerates to edge mode; with a period
  // of one the down leg is empty, so the boundary is reached at the top of the up leg.
  always_comb begin
    // NOTE: every output of this block is assigned before any branch, so no latches form.
    center_eff = mode_act && (per_act != '0);
    period_end = center_eff ? ((cnt == CNT_ONE) && ((dir == DIR_DOWN) || (per_act == CNT_ONE)))
                            : (cnt == per_act);
    reload     = !en || period_end;
    cnt_next   = cnt + CNT_ONE;
    dir_next   = dir;
    if (reload) begin
      cnt_next = '0;
      dir_next = DIR_UP;
    end else if (center_eff) begin
      if (dir == DIR_DOWN) begin
        cnt_next = cnt - CNT_ONE;
      end else if (cnt == per_act) begin
        cnt_next = cnt - CNT_ONE;
        dir_next = DIR_DOWN;
      end
    end
  end

  // Output decode; registered below so outputs trail cnt by one cycle.
  always_comb begin
    pwm_next  = '0;
    tick_next = en && period_end;
    for (int i = 0; i < CH; i++) pwm_next[i] = en && (cnt < duty_act[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out     <= '0;
      period_tick <= 1'b0;
    end else begin
      pwm_out     <= pwm_next;
      period_tick <= tick_next;
    end
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Bench for pwm_multi_gen: a phase-index reference model checked every cycle, directed
// scenarios with hand-computed expectations, then randomized configuration traffic.
module tb_pwm_multi_gen;

  localparam int CH    = 4;
  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             center;
  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_wdata;
  logic [CH-1:0]    pwm_out;
  logic             period_tick;

  int vectors     = 0;
  int miscompares = 0;
  bit check_on    = 1'b0;

  pwm_multi_gen #(.CH(CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(3999)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .center     (center),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .pwm_out    (pwm_out),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position k within the current period, from which the counter value
  // follows arithmetically (edge: k; center: k going up, then 2P-k coming down).
  int          m_per_sh, m_per_act, m_k;
  int          m_duty_sh [CH];
  int          m_duty_act[CH];
  bit          m_center;
  logic [CH-1:0] exp_pwm;
  logic        exp_tick;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_per_sh = 3999; m_per_act = 3999; m_center = 1'b0; m_k = 0;
        for (int i = 0; i < CH; i++) begin m_duty_sh[i] = 0; m_duty_act[i] = 0; end
        exp_pwm = '0; exp_tick = 1'b0;
      end else begin
        automatic bit ce   = m_center && (m_per_act != 0);
        automatic int len  = ce ? 2 * m_per_act : m_per_act + 1;
        automatic int c    = (ce && m_k > m_per_act) ? 2 * m_per_act - m_k : m_k;
        automatic bit last = (m_k == len - 1);
        for (int i = 0; i < CH; i++) exp_pwm[i] = en && (c < m_duty_act[i]);
        exp_tick = en && last;
        if (!en || last) begin
          m_per_act = m_per_sh;
          m_center  = center;
          for (int i = 0; i < CH; i++) m_duty_act[i] = m_duty_sh[i];
          m_k = 0;
        end else begin
          m_k = m_k + 1;
        end
        if (cfg_we) begin
          if (cfg_addr == 3'd0) m_per_sh = int'(cfg_wdata);
          else if (int'(cfg_addr) <= CH) m_duty_sh[int'(cfg_addr) - 1] = int'(cfg_wdata);
        end
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_on) begin
        vectors++;
        if ({pwm_out, period_tick} !== {exp_pwm, exp_tick}) begin
          miscompares++;
          $display("FAIL model_cycle t=%0t: got pwm_out=%b tick=%b, expected pwm_out=%b tick=%b",
                   $time, pwm_out, period_tick, exp_pwm, exp_tick);
        end
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(addr);
    cfg_wdata = CNT_W'(data);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  // Counts negedges until period_tick is seen, giving up after budget cycles.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < budget);
  endtask

  // Starting on a tick cycle, counts channel-0 high cycles over one period of len cycles,
  // optionally writing duty0 on the edge that ends cycle write_at.
  task automatic run_period(input int len, input int write_at, input int wdata, output int hi);
    hi = 0;
    for (int c = 0; c < len; c++) begin
      hi += int'(pwm_out[0]);
      cfg_we    = (c == write_at);
      cfg_addr  = 3'd1;
      cfg_wdata = CNT_W'(wdata);
      @(negedge clk);
    end
    cfg_we = 1'b0;
    check("period_sync", int'(period_tick), 1);
  endtask

  int n, hi0;
  int hi[CH];
  int ticks;

  initial begin
    rst = 1'b1; en = 1'b0; center = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_tick", int'(period_tick), 0);
    check_on = 1'b1;

    // Reset defaults: 4000-cycle period, all outputs low.
    en = 1'b1; rst = 1'b0;
    wait_tick(4100, n);  check("default_first_tick", n, 4000);
    wait_tick(4100, n);  check("default_tick_interval", n, 4000);

    // Edge mode, period 3.
    en = 1'b0;
    cfg_write(0, 3); cfg_write(1, 2); cfg_write(2, 0); cfg_write(3, 4); cfg_write(4, 3);
    @(negedge clk);
    en = 1'b1;
    wait_tick(100, n);  check("edge_first_tick", n, 4);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
      @(negedge clk);
    end
    check("edge_tick_period4", int'(period_tick), 1);
    check("edge_ch0_high", hi[0], 2);
    check("edge_ch1_high", hi[1], 0);
    check("edge_ch2_high", hi[2], 4);
    check("edge_ch3_high", hi[3], 3);

    // Center mode, period 4.
    en = 1'b0; center = 1'b1;
    cfg_write(0, 4); cfg_write(1, 2); cfg_write(2, 5);
    @(negedge clk);
    en = 1'b1;
    wait_tick(100, n);  check("center_first_tick", n, 8);
    check("center_ch0_at_tick", int'(pwm_out[0]), 1);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
      @(negedge clk);
    end
    check("center_tick_period8", int'(period_tick), 1);
    check("center_ch0_high", hi[0], 3);
    check("center_ch1_high", hi[1], 8);

    // Shadow timing, edge mode, period 9.
    en = 1'b0; center = 1'b0;
    cfg_write(0, 9); cfg_write(1, 2);
    @(negedge clk);
    en = 1'b1;
    wait_tick(100, n);  check("shadow_first_tick", n, 10);
    run_period(10, 3, 7, hi0);   check("shadow_mid_write_old", hi0, 2);
    run_period(10, -1, 0, hi0);  check("shadow_mid_write_new", hi0, 7);
    run_period(10, 9, 3, hi0);   check("shadow_reload_write_cur", hi0, 7);
    run_period(10, -1, 0, hi0);  check("shadow_reload_deferred", hi0, 7);
    run_period(10, -1, 0, hi0);  check("shadow_reload_applied", hi0, 3);

    // Enable toggle at cnt=5.
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("disable_pwm", int'(pwm_out), 0);
    check("disable_tick", int'(period_tick), 0);
    cfg_write(1, 5);
    @(negedge clk);
    en = 1'b1;
    hi0 = 0; ticks = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      hi0 += int'(pwm_out[0]);
      ticks += int'(period_tick);
    end
    check("reenable_high", hi0, 5);
    check("reenable_tick_at_10", int'(period_tick), 1);
    check("reenable_tick_count", ticks, 1);

    // Async reset in center mode while counting down.
    en = 1'b0; center = 1'b1;
    cfg_write(0, 6); cfg_write(1, 6);
    @(negedge clk);
    en = 1'b1;
    wait_tick(100, n);  check("prereset_first_tick", n, 12);
    repeat (8) @(negedge clk);
    check("prereset_pwm_high", int'(pwm_out[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_pwm", int'(pwm_out), 0);
    check("async_reset_tick", int'(period_tick), 0);
    center = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_tick(4100, n);  check("reset_period_restored", n, 4000);

    // Randomized configuration traffic, checked by the model every cycle.
    for (int c = 0; c < 2500; c++) begin
      en     = ($urandom_range(0, 19) != 0);
      center = ($urandom_range(0, 49) == 0) ? ~center : center;
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      cfg_wdata = (cfg_addr == 3'd0) ? CNT_W'($urandom_range(0, 12)) : CNT_W'($urandom_range(0, 15));
      @(negedge clk);
    end
    cfg_we = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
